axi_lite_spi_regs: RTL and testbench
====================================

Name: axi_lite_spi_regs

Overview:
AXI4-Lite slave register block that sits directly upstream of the SPI master. It converts CPU register writes into single-word TX handshakes and captures each received word into a readable RX register. It also exposes status, a sticky overrun flag and a level interrupt. It holds one TX word and one RX word; there is no deeper FIFO.

Parameters:
ADDR_WIDTH, 4, AXI address width (byte address; bits [3:2] select the register)
AXI_DATA_WIDTH, 32, AXI data bus width
SPI_WIDTH, 8, SPI word width; must be ≤ AXI_DATA_WIDTH

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel
s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel
spi_tx_valid  out  1  TX word available to the SPI master
spi_tx_data  out  SPI_WIDTH  TX word
spi_tx_ready  in  1  SPI master idle; a transfer occurs when valid and ready are both high
spi_rx_data  in  SPI_WIDTH  received word
spi_rx_valid  in  1  one-cycle strobe; spi_rx_data is valid in the same cycle
irq  out  1  interrupt, active-high level

Behaviour:
- Reset: all ready/valid outputs are 0. bresp and rresp are 0, rdata is 0. Registers CTRL, TX_HOLD, RX_DATA and all flags are 0. irq is 0.
- Register map:
  - 0x0 CTRL (RW): bit0 EN, bit1 IRQ_EN.
  - 0x4 STATUS (RO, except bit3 which is W1C): bit0 TX_FULL, bit1 RX_AVAIL, bit2 BUSY, bit3 RX_OVR.
  - 0x8 TXDATA (WO): reads return 0 with OKAY.
  - 0xC RXDATA (RO): writes are ignored and return OKAY.
- Unused data bits read as 0. Only wstrb[0] is honoured for CTRL and TXDATA; other strobe bits are ignored.
- Write path:
  - AW and W are accepted independently. Each ready is high while that channel's capture slot is empty and bvalid is 0.
  - Once both are captured, the register update and bvalid occur on the next cycle.
  - bvalid is held until bready. Only one write is outstanding at a time.
- TXDATA write when TX_FULL=0: TX_HOLD is loaded, TX_FULL is set, response is OKAY.
- TXDATA write when TX_FULL=1: data is dropped, response is SLVERR (2'b10).
- spi_tx_valid = TX_FULL & EN.
- On the spi_tx_valid & spi_tx_ready handshake: TX_FULL clears and BUSY sets, both on the next edge.
- Clearing EN blocks new handshakes. A transfer already in flight completes.
- spi_rx_valid:
  - RX_DATA ← spi_rx_data, RX_AVAIL sets, BUSY clears.
  - If RX_AVAIL was already 1 and not being read in the same cycle, RX_OVR also sets.
- Read path:
  - arready is high when rvalid=0.
  - rdata, rresp and rvalid are registered one cycle after the AR handshake and held until rready.
  - A read of RXDATA clears RX_AVAIL on the AR handshake cycle.
- Simultaneous RXDATA read and spi_rx_valid: the read returns the old data. RX_AVAIL remains 1 holding the new word. RX_OVR is not set.
- Simultaneous W1C of RX_OVR and a new overrun: set wins.
- A TX handshake and a TXDATA write can occur in the same cycle when TX_FULL=1; that write is still rejected, because the decision uses the pre-edge TX_FULL.
- irq = IRQ_EN & (RX_AVAIL | RX_OVR), registered.
- Asynchronous reset mid-transaction aborts every channel. Any pending response is dropped. No response is issued after reset.

Decomposition:
- Package axi_spi_pkg holds:
  - register offset localparams (REG_CTRL, REG_STATUS, REG_TXDATA, REG_RXDATA)
  - bit-position constants for CTRL and STATUS
  - the resp_t enum (OKAY=2'b00, SLVERR=2'b10)
- Single module; no sub-module is needed. The read and write channel FSMs are written as separate always_ff blocks within it.

Test Plan:
- Reset, then read STATUS → rdata=0x0, rresp=OKAY; irq=0; spi_tx_valid=0.
- Write CTRL=0x1 (EN), write TXDATA=0xA5, hold spi_tx_ready=1 → spi_tx_valid for exactly one cycle with data 0xA5; STATUS reads BUSY=1, TX_FULL=0.
- Keep spi_tx_ready=0, write TXDATA=0x11 then 0x22 → first write returns OKAY, second returns SLVERR; after ready rises, spi_tx_data=0x11.
- Pulse spi_rx_valid with 0x3C, then again with 0x5A without reading → RXDATA reads 0x5A; STATUS=0xA (RX_AVAIL, RX_OVR); write STATUS=0x8 → RX_OVR clears.
- CTRL=0x3 (EN, IRQ_EN), spi_rx_valid with 0x77 → irq rises; read RXDATA returns 0x77; irq falls.
- AW presented 3 cycles before W, with bready held low for 4 cycles → single bvalid, held until bready; no second AW accepted meanwhile. Unmapped or RO-space access checks per the map: RXDATA write → OKAY, no side effect.

Source files
------------

// File: rtl/axi_spi_pkg.sv
// Shared register map, bit positions and response codes for the AXI-Lite SPI register block.
package axi_spi_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_TXDATA = 2'd2;
   localparam logic [1:0] REG_RXDATA = 2'd3;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;

   localparam int unsigned STAT_TX_FULL  = 0;
   localparam int unsigned STAT_RX_AVAIL = 1;
   localparam int unsigned STAT_BUSY     = 2;
   localparam int unsigned STAT_RX_OVR   = 3;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

endpackage

// File: rtl/axi_lite_spi_regs.sv
// AXI4-Lite register front end for the SPI master: one TX holding word, one RX word,
// status flags with sticky overrun, and a registered level interrupt.
module axi_lite_spi_regs
   import axi_spi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned SPI_WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [ADDR_WIDTH-1:0]         s_awaddr,
   input  logic                          s_awvalid,
   output logic                          s_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                          s_wvalid,
   output logic                          s_wready,
   output logic [1:0]                    s_bresp,
   output logic                          s_bvalid,
   input  logic                          s_bready,
   input  logic [ADDR_WIDTH-1:0]         s_araddr,
   input  logic                          s_arvalid,
   output logic                          s_arready,
   output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                    s_rresp,
   output logic                          s_rvalid,
   input  logic                          s_rready,
   output logic                          spi_tx_valid,
   output logic [SPI_WIDTH-1:0]          spi_tx_data,
   input  logic                          spi_tx_ready,
   input  logic [SPI_WIDTH-1:0]          spi_rx_data,
   input  logic                          spi_rx_valid,
   output logic                          irq
);

   // Write channel state
   logic                      init_q;
   logic                      aw_full_q;
   logic [1:0]                awsel_q;
   logic                      w_full_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic                      wstrb0_q;
   logic                      bvalid_q;
   resp_t                     bresp_q;

   // Register state
   logic                      ctrl_en_q, ctrl_irq_en_q;
   logic [SPI_WIDTH-1:0]      tx_hold_q;
   logic                      tx_full_q, tx_full_d;
   logic                      busy_q, busy_d;
   logic [SPI_WIDTH-1:0]      rx_data_q;
   logic                      rx_avail_q, rx_avail_d;
   logic                      rx_ovr_q, rx_ovr_d;
   logic                      irq_q;

   // Read channel state
   logic                      rvalid_q;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   resp_t                     rresp_q;

   logic wr_en, wr_ctrl, wr_status, wr_tx, tx_load, tx_rej, tx_hs, rd_hs, rd_rx;

   // init_q keeps every ready low while in reset and for the first cycle after it
   assign s_awready    = init_q & ~aw_full_q & ~bvalid_q;
   assign s_wready     = init_q & ~w_full_q & ~bvalid_q;
   assign s_bvalid     = bvalid_q;
   assign s_bresp      = bresp_q;
   assign s_arready    = init_q & ~rvalid_q;
   assign s_rvalid     = rvalid_q;
   assign s_rdata      = rdata_q;
   assign s_rresp      = rresp_q;
   assign spi_tx_valid = tx_full_q & ctrl_en_q;
   assign spi_tx_data  = tx_hold_q;
   assign irq          = irq_q;

   always_comb begin
      wr_en     = aw_full_q & w_full_q;
      wr_ctrl   = wr_en & (awsel_q == REG_CTRL) & wstrb0_q;
      wr_status = wr_en & (awsel_q == REG_STATUS) & wstrb0_q;
      wr_tx     = wr_en & (awsel_q == REG_TXDATA);
      tx_rej    = wr_tx & tx_full_q;
      tx_load   = wr_tx & ~tx_full_q & wstrb0_q;
      tx_hs     = spi_tx_valid & spi_tx_ready;
      rd_hs     = s_arvalid & s_arready;
      rd_rx     = rd_hs & (s_araddr[3:2] == REG_RXDATA);
   end

   always_comb begin
      tx_full_d  = tx_full_q;
      busy_d     = busy_q;
      rx_avail_d = rx_avail_q;
      rx_ovr_d   = rx_ovr_q;
      if (tx_hs) begin
         tx_full_d = 1'b0;
      end else if (tx_load) begin
         tx_full_d = 1'b1;
      end
      // A new handshake outranks the completion of the previous transfer
      if (tx_hs) begin
         busy_d = 1'b1;
      end else if (spi_rx_valid) begin
         busy_d = 1'b0;
      end
      if (spi_rx_valid) begin
         rx_avail_d = 1'b1;
      end else if (rd_rx) begin
         rx_avail_d = 1'b0;
      end
      if (spi_rx_valid && rx_avail_q && !rd_rx) begin
         rx_ovr_d = 1'b1;
      end else if (wr_status && wdata_q[STAT_RX_OVR]) begin
         rx_ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q    <= 1'b0;
         aw_full_q <= 1'b0;
         awsel_q   <= 2'd0;
         w_full_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb0_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
      end else begin
         init_q <= 1'b1;
         if (s_awvalid && s_awready) begin
            aw_full_q <= 1'b1;
            awsel_q   <= s_awaddr[3:2];
         end else if (wr_en) begin
            aw_full_q <= 1'b0;
         end
         if (s_wvalid && s_wready) begin
            w_full_q <= 1'b1;
            wdata_q  <= s_wdata;
            wstrb0_q <= s_wstrb[0];
         end else if (wr_en) begin
            w_full_q <= 1'b0;
         end
         if (wr_en) begin
            bvalid_q <= 1'b1;
            bresp_q  <= tx_rej ? SLVERR : OKAY;
         end else if (bvalid_q && s_bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_en_q     <= 1'b0;
         ctrl_irq_en_q <= 1'b0;
         tx_hold_q     <= '0;
         tx_full_q     <= 1'b0;
         busy_q        <= 1'b0;
         rx_data_q     <= '0;
         rx_avail_q    <= 1'b0;
         rx_ovr_q      <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en_q     <= wdata_q[CTRL_EN];
            ctrl_irq_en_q <= wdata_q[CTRL_IRQ_EN];
         end
         if (tx_load) begin
            tx_hold_q <= wdata_q[SPI_WIDTH-1:0];
         end
         if (spi_rx_valid) begin
            rx_data_q <= spi_rx_data;
         end
         tx_full_q  <= tx_full_d;
         busy_q     <= busy_d;
         rx_avail_q <= rx_avail_d;
         rx_ovr_q   <= rx_ovr_d;
         irq_q      <= ctrl_irq_en_q & (rx_avail_q | rx_ovr_q);
      end
   end

   always_comb begin
      rdata_d = '0;
      unique case (s_araddr[3:2])
         REG_CTRL: begin
            rdata_d[CTRL_EN]     = ctrl_en_q;
            rdata_d[CTRL_IRQ_EN] = ctrl_irq_en_q;
         end
         REG_STATUS: begin
            rdata_d[STAT_TX_FULL]  = tx_full_q;
            rdata_d[STAT_RX_AVAIL] = rx_avail_q;
            rdata_d[STAT_BUSY]     = busy_q;
            rdata_d[STAT_RX_OVR]   = rx_ovr_q;
         end
         REG_RXDATA: rdata_d[SPI_WIDTH-1:0] = rx_data_q;
         default:    rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
      end else begin
         if (rd_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= OKAY;
         end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_spi_regs.sv
// Directed self-checking bench for axi_lite_spi_regs.
module tb_axi_lite_spi_regs;

   logic        clk;
   logic        rst_n;
   logic [3:0]  s_awaddr;
   logic        s_awvalid, s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid, s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid, s_bready;
   logic [3:0]  s_araddr;
   logic        s_arvalid, s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid, s_rready;
   logic        spi_tx_valid;
   logic [7:0]  spi_tx_data;
   logic        spi_tx_ready;
   logic [7:0]  spi_rx_data;
   logic        spi_rx_valid;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;
   int tx_hs_cnt = 0;
   logic [7:0] tx_last = 8'h00;

   axi_lite_spi_regs #(
      .ADDR_WIDTH(4), .AXI_DATA_WIDTH(32), .SPI_WIDTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (spi_tx_valid && spi_tx_ready) begin
         tx_hs_cnt <= tx_hs_cnt + 1;
         tx_last   <= spi_tx_data;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, b_done = 0;
      bit aw_hs, w_hs;
      resp = 2'bxx;
      @(posedge clk); #1;
      s_awaddr = addr; s_awvalid = 1'b1;
      s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
      s_bready = 1'b1;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         @(negedge clk);
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         @(posedge clk); #1;
         if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
         if (w_hs) begin w_done = 1; s_wvalid = 1'b0; end
      end
      for (int i = 0; i < 20 && !b_done; i++) begin
         @(negedge clk);
         if (s_bvalid) begin
            resp = s_bresp;
            b_done = 1;
         end
         @(posedge clk); #1;
      end
      s_bready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      if (!b_done) begin
         n_tests++; n_fail++;
         $display("FAIL write_timeout addr=0x%0h: got no bvalid, required bvalid", addr);
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit ar_done = 0, r_done = 0;
      bit ar_hs;
      data = 'x; resp = 2'bxx;
      @(posedge clk); #1;
      s_araddr = addr; s_arvalid = 1'b1;
      for (int i = 0; i < 20 && !ar_done; i++) begin
         @(negedge clk);
         ar_hs = s_arready;
         @(posedge clk); #1;
         if (ar_hs) begin ar_done = 1; s_arvalid = 1'b0; end
      end
      s_rready = 1'b1;
      for (int i = 0; i < 20 && !r_done; i++) begin
         @(negedge clk);
         if (s_rvalid) begin
            data = s_rdata; resp = s_rresp; r_done = 1;
         end
         @(posedge clk); #1;
      end
      s_rready = 1'b0; s_arvalid = 1'b0;
      if (!r_done) begin
         n_tests++; n_fail++;
         $display("FAIL read_timeout addr=0x%0h: got no rvalid, required rvalid", addr);
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      @(posedge clk); #1;
      spi_rx_data = d; spi_rx_valid = 1'b1;
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r;
      rst_n = 1'b0;
      wait_cycles(3);
      n_tests++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, spi_tx_valid, irq} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got 0b%07b required 0b0000000",
                  {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, spi_tx_valid, irq});
      end
      n_tests++;
      if (s_rdata !== 32'h0 || s_bresp !== 2'b00 || s_rresp !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_data: got rdata=0x%0h bresp=%0d rresp=%0d required 0/0/0",
                  s_rdata, s_bresp, s_rresp);
      end
      rst_n = 1'b1;
      wait_cycles(2);
      axi_read(4'h4, d, r);
      check("reset_status", d, 32'h0);
      check("reset_status_rresp", {30'b0, r}, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      check("reset_tx_valid", {31'b0, spi_tx_valid}, 32'h0);
   endtask

   task automatic test_tx_basic();
      logic [31:0] d; logic [1:0] r; int c0;
      spi_tx_ready = 1'b1;
      axi_write(4'h0, 32'h1, 4'hF, r);
      check("ctrl_en_resp", {30'b0, r}, 32'h0);
      c0 = tx_hs_cnt;
      axi_write(4'h8, 32'hA5, 4'hF, r);
      check("tx_a5_resp", {30'b0, r}, 32'h0);
      wait_cycles(3);
      check("tx_a5_hs_count", tx_hs_cnt - c0, 32'd1);
      check("tx_a5_data", {24'b0, tx_last}, 32'hA5);
      axi_read(4'h4, d, r);
      check("status_busy", d, 32'h4);
      axi_read(4'h8, d, r);
      check("txdata_read_zero", d, 32'h0);
      check("txdata_read_resp", {30'b0, r}, 32'h0);
   endtask

   task automatic test_tx_full();
      logic [1:0] r; int c0;
      spi_tx_ready = 1'b0;
      c0 = tx_hs_cnt;
      axi_write(4'h8, 32'h11, 4'hF, r);
      check("tx_11_resp", {30'b0, r}, 32'h0);
      axi_write(4'h8, 32'h22, 4'hF, r);
      check("tx_22_slverr", {30'b0, r}, 32'h2);
      check("tx_hold_data", {24'b0, spi_tx_data}, 32'h11);
      check("tx_hold_valid", {31'b0, spi_tx_valid}, 32'h1);
      spi_tx_ready = 1'b1;
      wait_cycles(3);
      spi_tx_ready = 1'b0;
      check("tx_11_hs_count", tx_hs_cnt - c0, 32'd1);
      check("tx_11_sent", {24'b0, tx_last}, 32'h11);
   endtask

   task automatic test_rx_overrun();
      logic [31:0] d; logic [1:0] r;
      rx_pulse(8'h3C);
      rx_pulse(8'h5A);
      axi_read(4'h4, d, r);
      check("status_avail_ovr", d, 32'hA);
      axi_read(4'hC, d, r);
      check("rxdata_5a", d, 32'h5A);
      axi_read(4'h4, d, r);
      check("status_ovr_only", d, 32'h8);
      axi_write(4'h4, 32'h8, 4'hF, r);
      check("w1c_resp", {30'b0, r}, 32'h0);
      axi_read(4'h4, d, r);
      check("status_ovr_cleared", d, 32'h0);
   endtask

   task automatic test_irq();
      logic [31:0] d; logic [1:0] r;
      axi_write(4'h0, 32'h3, 4'hF, r);
      wait_cycles(2);
      check("irq_idle", {31'b0, irq}, 32'h0);
      rx_pulse(8'h77);
      wait_cycles(3);
      check("irq_rise", {31'b0, irq}, 32'h1);
      axi_read(4'hC, d, r);
      check("rxdata_77", d, 32'h77);
      wait_cycles(3);
      check("irq_fall", {31'b0, irq}, 32'h0);
   endtask

   task automatic test_read_rx_collision();
      logic [31:0] d; logic [1:0] r;
      bit got = 0;
      rx_pulse(8'h10);
      @(posedge clk); #1;
      s_araddr = 4'hC; s_arvalid = 1'b1;
      spi_rx_data = 8'h20; spi_rx_valid = 1'b1;
      @(posedge clk); #1;
      s_arvalid = 1'b0; spi_rx_valid = 1'b0; s_rready = 1'b1;
      d = 'x;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (s_rvalid) begin d = s_rdata; got = 1; end
         @(posedge clk); #1;
      end
      s_rready = 1'b0;
      check("collide_old_data", d, 32'h10);
      axi_read(4'h4, d, r);
      check("collide_status", d, 32'h2);
      axi_read(4'hC, d, r);
      check("collide_new_data", d, 32'h20);
      axi_write(4'hC, 32'hFF, 4'hF, r);
      check("rxdata_write_okay", {30'b0, r}, 32'h0);
      axi_read(4'hC, d, r);
      check("rxdata_write_ignored", d, 32'h20);
      axi_read(4'h4, d, r);
      check("status_after_rx_write", d, 32'h0);
   endtask

   task automatic test_split_write();
      logic [31:0] d; logic [1:0] r;
      bit seen = 0;
      int hi = 0, after = 0;
      @(posedge clk); #1;
      s_awaddr = 4'h0; s_awvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b0;
      @(negedge clk);
      check("split_awready", {31'b0, s_awready}, 32'h1);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      wait_cycles(2);
      check("split_aw_held", {31'b0, s_awready}, 32'h0);
      s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk);
      check("split_wready", {31'b0, s_wready}, 32'h1);
      @(posedge clk); #1;
      s_wvalid = 1'b0;
      @(negedge clk);
      check("split_b_latency0", {31'b0, s_bvalid}, 32'h0);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = s_bvalid;
      end
      check("split_bvalid_seen", {31'b0, seen}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (s_bvalid && !s_awready && !s_wready) hi++;
      end
      check("split_bvalid_held", hi, 32'd4);
      check("split_bresp", {30'b0, s_bresp}, 32'h0);
      @(posedge clk); #1;
      s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (s_bvalid) after++;
      end
      check("split_single_bvalid", after, 32'd0);
      check("split_awready_back", {31'b0, s_awready}, 32'h1);
      axi_read(4'h0, d, r);
      check("split_ctrl_value", d, 32'h1);
   endtask

   initial begin
      rst_n = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      spi_tx_ready = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
      test_reset();
      test_tx_basic();
      test_tx_full();
      test_rx_overrun();
      test_irq();
      test_read_rx_collision();
      test_split_write();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
